// File: rtl/cpu_gen2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_gen2_pkg
// Description : Shared opcode encodings and FSM state type for cpu_gen2.
//               Instruction word is {opcode[3:0], imm[DW-1:0]}.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_gen2_pkg;

    localparam logic [3:0] OP_ADD_A  = 4'b0000;  // {cf,a} = a + imm
    localparam logic [3:0] OP_MOV_AB = 4'b0001;  // a = b
    localparam logic [3:0] OP_IN_A   = 4'b0010;  // a = switch (polarity adjusted)
    localparam logic [3:0] OP_MOV_A  = 4'b0011;  // a = imm
    localparam logic [3:0] OP_MOV_BA = 4'b0100;  // b = a
    localparam logic [3:0] OP_ADD_B  = 4'b0101;  // {cf,b} = b + imm
    localparam logic [3:0] OP_IN_B   = 4'b0110;  // b = switch (polarity adjusted)
    localparam logic [3:0] OP_MOV_B  = 4'b0111;  // b = imm
    localparam logic [3:0] OP_ADD_AB = 4'b1000;  // {cf,a} = a + b
    localparam logic [3:0] OP_OUT_B  = 4'b1001;  // led = b
    localparam logic [3:0] OP_JZ     = 4'b1010;  // ip = imm if zf
    localparam logic [3:0] OP_OUT_I  = 4'b1011;  // led = imm
    localparam logic [3:0] OP_CALL   = 4'b1100;  // push ip+1, ip = imm
    localparam logic [3:0] OP_RET    = 4'b1101;  // ip = pop
    localparam logic [3:0] OP_JNC    = 4'b1110;  // ip = imm if !cf
    localparam logic [3:0] OP_JMP    = 4'b1111;  // ip = imm

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        FAULT = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/cpu_gen2_if.sv
`default_nettype none
// ============================================================================
// Module      : cpu_gen2_if
// Description : Program-ROM fetch bus with req/valid handshake.
//   rom_req   : CPU requests an instruction at rom_addr
//   rom_addr  : fetch address (AW bits)
//   rom_data  : instruction word {opcode[3:0], imm[DW-1:0]}
//   rom_valid : rom_data is valid this cycle
//   master modport = CPU side, slave modport = ROM side
// Revision    : 1.0 - initial release
// ============================================================================
interface cpu_gen2_if #(
    parameter int DW = 4,
    parameter int AW = 4
);
    logic          rom_req;
    logic [AW-1:0] rom_addr;
    logic [DW+3:0] rom_data;
    logic          rom_valid;

    modport master (
        output rom_req,
        output rom_addr,
        input  rom_data,
        input  rom_valid
    );

    modport slave (
        input  rom_req,
        input  rom_addr,
        output rom_data,
        output rom_valid
    );
endinterface
`default_nettype wire

// File: rtl/cpu_gen2_stack.sv
`default_nettype none
// ============================================================================
// Module      : cpu_gen2_stack
// Description : Parametrised LIFO used as the hardware return stack.
//   clk, reset : clock, asynchronous active-high reset (clears contents)
//   push, din  : write din on top (ignored when full)
//   pop        : drop the top entry (ignored when empty)
//   top        : current top entry (0 when empty)
//   full/empty : occupancy flags
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_gen2_stack #(
    parameter int DW    = 4,
    parameter int DEPTH = 4
) (
    input  wire logic          clk,
    input  wire logic          reset,
    input  wire logic          push,
    input  wire logic          pop,
    input  wire logic [DW-1:0] din,
    output logic      [DW-1:0] top,
    output logic               full,
    output logic               empty
);
    // Pointer must represent 0..DEPTH inclusive.
    localparam int SPW   = $clog2(DEPTH + 1);
    // Storage is sized to the pointer range so the pointer indexes it directly;
    // slots at or above DEPTH are never written.
    localparam int SLOTS = 1 << SPW;

    logic [DW-1:0]  r_mem [SLOTS];
    logic [SPW-1:0] r_sp;
    logic [SPW-1:0] w_top_idx;

    assign w_top_idx = r_sp - SPW'(1);
    assign full      = (r_sp == SPW'(DEPTH));
    assign empty     = (r_sp == '0);
    assign top       = empty ? '0 : r_mem[w_top_idx];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SLOTS; i++) begin
                r_mem[i] <= '0;
            end
            r_sp <= '0;
        end else if (push && !full) begin
            r_mem[r_sp] <= din;
            r_sp        <= r_sp + SPW'(1);
        end else if (pop && !empty) begin
            r_sp <= r_sp - SPW'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/cpu_gen2.sv
`default_nettype none
// ============================================================================
// Module      : cpu_gen2
// Description : Parametrised accumulator CPU with A/B registers, carry and
//               zero flags, JMP/JNC/JZ, CALL/RET on a hardware return stack,
//               and a req/valid instruction fetch that tolerates wait states.
//   clk, reset : clock, asynchronous active-high reset
//   rom        : fetch bus (master side), rom_addr follows ip
//   switch     : board switches, read by IN A / IN B
//   led        : LED register written by OUT B / OUT imm
//   out_strobe : one-cycle pulse in the cycle after led is written
//   fault      : sticky stack over/underflow indication
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_gen2
    import cpu_gen2_pkg::*;
#(
    parameter int DW            = 4,
    parameter int AW            = 4,
    parameter int STACK_DEPTH   = 4,
    parameter bit SW_ACTIVE_LOW = 1'b1
) (
    input  wire logic          clk,
    input  wire logic          reset,
    cpu_gen2_if.master         rom,
    input  wire logic [DW-1:0] switch,
    output logic      [DW-1:0] led,
    output logic               out_strobe,
    output logic               fault
);

    state_t        r_state, w_state_nx;
    logic [DW-1:0] r_a, w_a_nx;
    logic [DW-1:0] r_b, w_b_nx;
    logic [DW-1:0] r_led, w_led_nx;
    logic [AW-1:0] r_ip, w_ip_nx;
    logic [DW+3:0] r_ir, w_ir_nx;
    logic          r_cf, w_cf_nx;
    logic          r_zf, w_zf_nx;
    logic          r_strobe, w_strobe_nx;

    logic [3:0]    w_op;
    logic [DW-1:0] w_imm;
    logic [AW-1:0] w_target;
    logic [AW-1:0] w_ip_inc;
    logic [DW-1:0] w_sw_val;
    logic [DW-1:0] w_add_x, w_add_y;
    logic [DW:0]   w_sum;
    logic          w_push, w_pop;
    logic [AW-1:0] w_top;
    logic          w_full, w_empty;

    assign w_op     = r_ir[DW+3:DW];
    assign w_imm    = r_ir[DW-1:0];
    assign w_target = w_imm[AW-1:0];
    assign w_ip_inc = r_ip + AW'(1);

    generate
        if (SW_ACTIVE_LOW) begin : g_sw_active_low
            assign w_sw_val = ~switch;
        end else begin : g_sw_active_high
            assign w_sw_val = switch;
        end
    endgenerate

    // Single shared adder; operand pair chosen by opcode.
    always_comb begin
        w_add_x = r_a;
        w_add_y = w_imm;
        case (w_op)
            OP_ADD_B:  begin w_add_x = r_b; w_add_y = w_imm; end
            OP_ADD_AB: begin w_add_x = r_a; w_add_y = r_b;   end
            default:   ;
        endcase
    end
    assign w_sum = {1'b0, w_add_x} + {1'b0, w_add_y};

    cpu_gen2_stack #(
        .DW    (AW),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_ip_inc),
        .top   (w_top),
        .full  (w_full),
        .empty (w_empty)
    );

    // Next-state and datapath decode.
    always_comb begin
        w_state_nx  = r_state;
        w_a_nx      = r_a;
        w_b_nx      = r_b;
        w_led_nx    = r_led;
        w_ip_nx     = r_ip;
        w_ir_nx     = r_ir;
        w_cf_nx     = r_cf;
        w_zf_nx     = r_zf;
        w_strobe_nx = 1'b0;
        w_push      = 1'b0;
        w_pop       = 1'b0;

        case (r_state)
            IDLE: w_state_nx = FETCH;

            FETCH: begin
                if (rom.rom_valid) begin
                    w_ir_nx    = rom.rom_data;
                    w_state_nx = EXEC;
                end
            end

            EXEC: begin
                w_state_nx = FETCH;
                w_ip_nx    = w_ip_inc;
                w_cf_nx    = 1'b0;
                w_zf_nx    = 1'b0;
                case (w_op)
                    OP_ADD_A, OP_ADD_AB: begin
                        w_a_nx  = w_sum[DW-1:0];
                        w_cf_nx = w_sum[DW];
                        w_zf_nx = (w_sum[DW-1:0] == '0);
                    end
                    OP_ADD_B: begin
                        w_b_nx  = w_sum[DW-1:0];
                        w_cf_nx = w_sum[DW];
                        w_zf_nx = (w_sum[DW-1:0] == '0);
                    end
                    OP_MOV_A:  w_a_nx = w_imm;
                    OP_MOV_B:  w_b_nx = w_imm;
                    OP_MOV_AB: w_a_nx = r_b;
                    OP_MOV_BA: w_b_nx = r_a;
                    OP_IN_A:   w_a_nx = w_sw_val;
                    OP_IN_B:   w_b_nx = w_sw_val;
                    OP_OUT_B: begin
                        w_led_nx    = r_b;
                        w_strobe_nx = 1'b1;
                    end
                    OP_OUT_I: begin
                        w_led_nx    = w_imm;
                        w_strobe_nx = 1'b1;
                    end
                    OP_JMP: w_ip_nx = w_target;
                    OP_JNC: if (!r_cf) w_ip_nx = w_target;
                    OP_JZ:  if (r_zf)  w_ip_nx = w_target;
                    OP_CALL: begin
                        if (w_full) begin
                            // Faulting instruction leaves all state untouched.
                            w_state_nx = FAULT;
                            w_ip_nx    = r_ip;
                            w_cf_nx    = r_cf;
                            w_zf_nx    = r_zf;
                        end else begin
                            w_push  = 1'b1;
                            w_ip_nx = w_target;
                        end
                    end
                    OP_RET: begin
                        if (w_empty) begin
                            w_state_nx = FAULT;
                            w_ip_nx    = r_ip;
                            w_cf_nx    = r_cf;
                            w_zf_nx    = r_zf;
                        end else begin
                            w_pop   = 1'b1;
                            w_ip_nx = w_top;
                        end
                    end
                    default: ;
                endcase
            end

            FAULT: w_state_nx = FAULT;

            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_led    <= '0;
            r_ip     <= '0;
            r_ir     <= '0;
            r_cf     <= 1'b0;
            r_zf     <= 1'b0;
            r_strobe <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_a      <= w_a_nx;
            r_b      <= w_b_nx;
            r_led    <= w_led_nx;
            r_ip     <= w_ip_nx;
            r_ir     <= w_ir_nx;
            r_cf     <= w_cf_nx;
            r_zf     <= w_zf_nx;
            r_strobe <= w_strobe_nx;
        end
    end

    assign rom.rom_req  = (r_state == FETCH);
    assign rom.rom_addr = r_ip;
    assign fault        = (r_state == FAULT);
    assign led          = r_led;
    assign out_strobe   = r_strobe;

endmodule
`default_nettype wire
